// File: rtl/imm_pkg.sv
// Package: imm_pkg
// Shared types and constants for the buffered immediate generator.
//  - imm_fmt_e : immediate format tag carried with every queued entry
//  - OPC_*     : RV32 major opcodes recognised by the decoder
//  - entry_t   : one FIFO entry {imm, fmt, illegal}; imm is stored at the
//                widest legal XLEN (64) and trimmed at the output port
// Optional feature macro used by the users of this package:
//  IMM_GEN_ILLEGAL_CHK_EN
package imm_pkg;

    localparam int IMM_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        imm_fmt_e         fmt;
        logic             illegal;
    } entry_t;

    // Sign-extend a 12-bit field to the storage width
    function automatic logic [IMM_W-1:0] sext12(input logic [11:0] v);
        return {{(IMM_W-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Module: imm_decode
// Purely combinational instruction -> queued entry decoder.
// Ports:
//  inst  in   32            raw RV instruction
//  entry out  entry_t       {imm (sign-extended, XLEN bits used), fmt, illegal}
// Parameter XLEN (32 or 64): with XLEN=32 the upper 32 storage bits are zero.
// Macro IMM_GEN_ILLEGAL_CHK_EN: when defined, an unknown opcode yields
// imm=0 with illegal=1; otherwise the raw instruction is zero-extended.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] inst,
    output entry_t      entry
);

    logic [2:0]       funct3_s;
    logic [IMM_W-1:0] imm_full_s;
    imm_fmt_e         fmt_s;
    logic             illegal_s;

    assign funct3_s = inst[14:12];

    // Format classification and 64-bit sign-extended immediate
    always_comb begin
        imm_full_s = 64'd0;
        fmt_s      = FMT_NONE;
        illegal_s  = 1'b0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD: begin
                fmt_s      = FMT_I;
                imm_full_s = sext12(inst[31:20]);
            end
            OPC_JALR: begin
                // JALR with a non-zero funct3 is treated as a branch-format immediate
                if (funct3_s == 3'b000) begin
                    fmt_s      = FMT_I;
                    imm_full_s = sext12(inst[31:20]);
                end else begin
                    fmt_s      = FMT_B;
                    imm_full_s = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
            end
            OPC_STORE: begin
                fmt_s      = FMT_S;
                imm_full_s = sext12({inst[31:25], inst[11:7]});
            end
            OPC_BRANCH: begin
                fmt_s      = FMT_B;
                imm_full_s = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_s      = FMT_U;
                imm_full_s = {{32{inst[31]}}, inst[31:12], 12'd0};
            end
            OPC_JAL: begin
                fmt_s      = FMT_J;
                imm_full_s = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
`ifdef IMM_GEN_ILLEGAL_CHK_EN
                imm_full_s = 64'd0;
                illegal_s  = 1'b1;
`else
                imm_full_s = {32'd0, inst};
                illegal_s  = 1'b0;
`endif
            end
        endcase
    end

    // A 32-bit core sees only the low word; U-format is then exactly inst[31:12]<<12
    assign entry.imm     = (XLEN == 32) ? {32'd0, imm_full_s[31:0]} : imm_full_s;
    assign entry.fmt     = fmt_s;
    assign entry.illegal = illegal_s;

endmodule

// File: rtl/imm_gen_pipe_chk.sv
// Module: imm_gen_pipe_chk
// Protocol checker for the immediate FIFO (simulation assertions only).
// Ports:
//  clk, rst_n  clock / async active-low reset
//  push        accepted write this cycle
//  pop         accepted read this cycle
//  count       current occupancy
module imm_gen_pipe_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count < CW'(DEPTH)));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        pop |-> (count != {CW{1'b0}}));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

endmodule

// File: rtl/imm_gen_pipe.sv
// Module: imm_gen_pipe
// Buffered immediate generator between IF/ID and execute. Decodes one RV
// instruction per accepted handshake and queues {imm, fmt, illegal} in a
// DEPTH-entry ring FIFO. Head-entry outputs are registered and hold their
// last value while the FIFO is empty.
// Parameters: XLEN (32|64) immediate width, DEPTH (power of two, >=2).
// Ports:
//  clk, rst_n            clock / asynchronous active-low reset
//  flush                 synchronous discard of all entries (drops same-cycle push)
//  in_valid, in_ready    input handshake; in_ready = count < DEPTH
//  inst [31:0]           raw instruction
//  out_valid, out_ready  output handshake on the head entry
//  imm [XLEN-1:0]        head immediate
//  imm_fmt [2:0]         head format (imm_fmt_e)
//  count                 occupancy
//  illegal               head had an unknown opcode (IMM_GEN_ILLEGAL_CHK_EN), else 0
// Macro: IMM_GEN_ILLEGAL_CHK_EN
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            imm,
    output logic [2:0]                 imm_fmt,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          mem_r [DEPTH];
    entry_t          head_r;
    entry_t          head_nxt_s;
    entry_t          dec_entry_s;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_nxt_s;
    logic [PW-1:0]   rd_ptr_nxt_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic            out_valid_r;
    logic            in_ready_s;
    logic            push_s;
    logic            pop_s;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst  (inst),
        .entry (dec_entry_s)
    );

    assign in_ready_s = (count_r < CW'(DEPTH));
    assign push_s     = in_valid && in_ready_s;
    assign pop_s      = out_valid_r && out_ready;

    // Next occupancy, pointers and head entry
    always_comb begin
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = head_r;
        if (flush) begin
            count_nxt_s  = {CW{1'b0}};
            wr_ptr_nxt_s = {PW{1'b0}};
            rd_ptr_nxt_s = {PW{1'b0}};
            head_nxt_s   = head_r;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
            // DEPTH is a power of two, so pointer overflow is the modulo wrap
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            // The new head is the entry being written right now when the
            // write slot coincides with the next read slot (push into empty,
            // or push+pop with a single entry); otherwise it is in storage.
            if (count_nxt_s != {CW{1'b0}}) begin
                if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                    head_nxt_s = dec_entry_s;
                end else begin
                    head_nxt_s = mem_r[rd_ptr_nxt_s];
                end
            end else begin
                head_nxt_s = head_r;
            end
        end
    end

    // Control state and registered head outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= {CW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            out_valid_r <= 1'b0;
            head_r      <= '0;
        end else begin
            count_r     <= count_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
            head_r      <= head_nxt_s;
        end
    end

    // Entry storage; a flush drops the same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= dec_entry_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign imm       = head_r.imm[XLEN-1:0];
    assign imm_fmt   = head_r.fmt;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
    assign illegal   = head_r.illegal;
`else
    // Decoder never sets the flag in this build, so the port is constant 0
    assign illegal   = head_r.illegal & 1'b0;
`endif

    imm_gen_pipe_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe (XLEN=64, DEPTH=2): directed vector table,
// hand-written handshake/flush/reset sequences, then randomized traffic
// checked against a queue-based reference model.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_I    = 3'd1;
    localparam logic [2:0] F_S    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_U    = 3'd4;
    localparam logic [2:0] F_J    = 3'd5;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [2:0]       imm_fmt;
    logic [1:0]       count;
    logic             illegal;

    imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .imm_fmt   (imm_fmt),
        .count     (count),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } mentry_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    mentry_t q[$];
    mentry_t shown;
    int      n_pass;
    int      n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference decode from the instruction-set immediate rules as signed integers
    function automatic mentry_t ref_decode(input logic [31:0] x);
        mentry_t e;
        longint  v;
        v     = 0;
        e.fmt = F_NONE;
        e.ill = 1'b0;
        case (x[6:0])
            7'h13, 7'h03: begin
                e.fmt = F_I;
                v = longint'(x[31:20]);
                if (x[31]) v = v - 64'sd4096;
            end
            7'h67: begin
                if (x[14:12] == 3'd0) begin
                    e.fmt = F_I;
                    v = longint'(x[31:20]);
                    if (x[31]) v = v - 64'sd4096;
                end else begin
                    e.fmt = F_B;
                    v = longint'(x[7]) * 64'sd2048 + longint'(x[30:25]) * 64'sd32 + longint'(x[11:8]) * 64'sd2;
                    if (x[31]) v = v - 64'sd4096;
                end
            end
            7'h23: begin
                e.fmt = F_S;
                v = longint'(x[31:25]) * 64'sd32 + longint'(x[11:7]);
                if (x[31]) v = v - 64'sd4096;
            end
            7'h63: begin
                e.fmt = F_B;
                v = longint'(x[7]) * 64'sd2048 + longint'(x[30:25]) * 64'sd32 + longint'(x[11:8]) * 64'sd2;
                if (x[31]) v = v - 64'sd4096;
            end
            7'h37, 7'h17: begin
                e.fmt = F_U;
                v = longint'(x[31:12]) * 64'sd4096;
                if (x[31]) v = v - 64'sd4294967296;
            end
            7'h6F: begin
                e.fmt = F_J;
                v = longint'(x[19:12]) * 64'sd4096 + longint'(x[20]) * 64'sd2048 + longint'(x[30:21]) * 64'sd2;
                if (x[31]) v = v - 64'sd1048576;
            end
            default: begin
`ifdef IMM_GEN_ILLEGAL_CHK_EN
                e.ill = 1'b1;
                v = 0;
`else
                v = longint'(x);
`endif
            end
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, "_count"},     64'(count),     64'(q.size()));
        chk({tag, "_imm"},       64'(imm),       shown.imm);
        chk({tag, "_fmt"},       64'(imm_fmt),   64'(shown.fmt));
        chk({tag, "_illegal"},   64'(illegal),   64'(shown.ill));
    endtask

    // One clock cycle: drive, check in_ready, advance model, check outputs
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        logic do_push;
        logic do_pop;
        in_valid  = iv;
        inst      = ins;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        do_push = iv && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(ref_decode(ins));
        end
        if (q.size() != 0) shown = q[0];
        #1;
        check_outputs("step");
    endtask

    vec_t vecs[11];

    localparam logic [6:0] OPCS [8] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst      = 32'd0;
        out_ready = 1'b0;
        shown     = '0;

        // Expected values worked out by hand from the encoding rules
        vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, F_I, 1'b0}; // addi -1
        vecs[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, F_S, 1'b0}; // sw -4
        vecs[2]  = '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, F_B, 1'b0}; // beq -8
        vecs[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, F_U, 1'b0}; // lui
        vecs[4]  = '{32'h0010006F, 64'h0000_0000_0000_0800, F_J, 1'b0}; // jal +2048
        vecs[5]  = '{32'h00001017, 64'h0000_0000_0000_1000, F_U, 1'b0}; // auipc
        vecs[6]  = '{32'h7FF00067, 64'h0000_0000_0000_07FF, F_I, 1'b0}; // jalr f3=000
        vecs[7]  = '{32'h80001067, 64'hFFFF_FFFF_FFFF_F000, F_B, 1'b0}; // jalr f3!=000
        vecs[8]  = '{32'h00402103, 64'h0000_0000_0000_0004, F_I, 1'b0}; // lw 4
        vecs[9]  = '{32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, F_J, 1'b0}; // jal most negative
`ifdef IMM_GEN_ILLEGAL_CHK_EN
        vecs[10] = '{32'h0000007F, 64'h0000_0000_0000_0000, F_NONE, 1'b1};
`else
        vecs[10] = '{32'h0000007F, 64'h0000_0000_0000_007F, F_NONE, 1'b0};
`endif

        // Reset state
        #2;
        check_outputs("reset");
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: push alone, head visible next cycle, then pop and hold
        for (int i = 0; i < 11; i++) begin
            step(1'b1, vecs[i].inst, 1'b0, 1'b0);
            chk("tbl_imm",  64'(imm),     vecs[i].imm);
            chk("tbl_fmt",  64'(imm_fmt), 64'(vecs[i].fmt));
            chk("tbl_ill",  64'(illegal), 64'(vecs[i].ill));
            step(1'b0, 32'd0, 1'b1, 1'b0);
            chk("tbl_hold_imm", 64'(imm), vecs[i].imm);
        end

        // S then B in order
        step(1'b1, 32'hFE112E23, 1'b0, 1'b0);
        step(1'b1, 32'hFE000CE3, 1'b0, 1'b0);
        chk("order_first", 64'(imm), 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("order_second", 64'(imm), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("order_second_fmt", 64'(imm_fmt), 64'(F_B));
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Back-pressure: third instruction stalls until space frees
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'h00402103, 1'b0, 1'b0);
        chk("bp_count", 64'(count), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'h00001017, 1'b0, 1'b0);
        step(1'b1, 32'h00001017, 1'b0, 1'b0);
        chk("bp_stall_head", 64'(imm), 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 32'h00001017, 1'b1, 1'b0);
        chk("bp_second", 64'(imm), 64'h4);
        step(1'b1, 32'h00001017, 1'b1, 1'b0);
        chk("bp_third", 64'(imm), 64'h1000);
        chk("bp_third_count", 64'(count), 64'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush while full with in_valid high
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'h00402103, 1'b0, 1'b0);
        step(1'b1, 32'h00001017, 1'b0, 1'b1);
        chk("flush_full_count", 64'(count), 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        // Flush with room: the same-cycle push is dropped
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'h0010006F, 1'b0, 1'b1);
        chk("flush_drop_count", 64'(count), 64'd0);
        chk("flush_drop_valid", 64'(out_valid), 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream
        step(1'b1, 32'hFE112E23, 1'b0, 1'b0);
        step(1'b1, 32'h800000B7, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        q.delete();
        shown = '0;
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            logic [6:0]  opc;
            int          sel;
            r   = $urandom;
            sel = int'($urandom_range(0, 8));
            if (sel < 8) opc = OPCS[sel];
            else opc = r[6:0];
            step(($urandom_range(0, 3) != 0), {r[31:7], opc},
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
